radix4_butterfly_stage: RTL

Pipelined radix-4 butterfly with twiddle rotation for the 16-point radix-4 FFT datapath. It sits directly downstream of the 16-sample input selector. Each valid cycle it takes one quad of four complex samples plus the 2-bit quad index. It produces four scaled, twiddle-rotated complex results for the second radix-4 pass. It also checks that quad indices arrive in order 0,1,2,3 and flags frame completion.

---
 rtl/radix4_butterfly_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/radix4_butterfly_stage.sv
// Pipelined radix-4 butterfly with twiddle rotation, /4 scaling and quad-order checking.
// Fixed 4-register pipeline: butterfly, products, accumulate, round/saturate.
module radix4_butterfly_stage #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*DW-1:0] in_0,
  input  logic [2*DW-1:0] in_1,
  input  logic [2*DW-1:0] in_2,
  input  logic [2*DW-1:0] in_3,
  input  logic            in_valid,
  input  logic [1:0]      q_flag,
  output logic [2*DW-1:0] out_0,
  output logic [2*DW-1:0] out_1,
  output logic [2*DW-1:0] out_2,
  output logic [2*DW-1:0] out_3,
  output logic            out_valid,
  output logic [1:0]      out_q,
  output logic            frame_done,
  output logic            seq_err
);

  localparam int XW = DW + 2;
  localparam int PW = XW + TW;
  localparam int AW = PW + 1;
  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (TW - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [XW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [XW-1:0] bf_re [4];
  logic signed [XW-1:0] bf_im [4];
  logic signed [XW-1:0] x_re [4];
  logic signed [XW-1:0] x_im [4];
  logic signed [TW-1:0] w_re [4];
  logic signed [TW-1:0] w_im [4];
  logic signed [PW-1:0] p_rr [4];
  logic signed [PW-1:0] p_ii [4];
  logic signed [PW-1:0] p_ri [4];
  logic signed [PW-1:0] p_ir [4];
  logic signed [AW-1:0] a_re [4];
  logic signed [AW-1:0] a_im [4];
  logic                 v1, v2, v3;
  logic [1:0]           q1, q2, q3;
  logic [1:0]           exp_q;

  assign ar = XW'($signed(in_0[2*DW-1:DW]));
  assign ai = XW'($signed(in_0[DW-1:0]));
  assign br = XW'($signed(in_1[2*DW-1:DW]));
  assign bi = XW'($signed(in_1[DW-1:0]));
  assign cr = XW'($signed(in_2[2*DW-1:DW]));
  assign ci = XW'($signed(in_2[DW-1:0]));
  assign dr = XW'($signed(in_3[2*DW-1:DW]));
  assign di = XW'($signed(in_3[DW-1:0]));

  // -j*(x+jy) = y-jx and j*(x+jy) = -y+jx folded into the add/sub pattern
  always_comb begin
    bf_re[0] = ar + br + cr + dr;
    bf_im[0] = ai + bi + ci + di;
    bf_re[1] = ar + bi - cr - di;
    bf_im[1] = ai - br - ci + dr;
    bf_re[2] = ar - br + cr - dr;
    bf_im[2] = ai - bi + ci - di;
    bf_re[3] = ar - bi - cr + di;
    bf_im[3] = ai + br - ci - dr;
  end

  // W16^n = cos - j*sin in Q1.14; only the exponents k*q can produce are stored
  function automatic logic [2*TW-1:0] twiddle(input logic [3:0] n);
    case (n)
      4'd1:    return {TW'(15137),  TW'(-6270)};
      4'd2:    return {TW'(11585),  TW'(-11585)};
      4'd3:    return {TW'(6270),   TW'(-15137)};
      4'd4:    return {TW'(0),      TW'(-16384)};
      4'd6:    return {TW'(-11585), TW'(-11585)};
      4'd9:    return {TW'(-15137), TW'(6270)};
      default: return {TW'(16384),  TW'(0)};
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      {w_re[k], w_im[k]} = twiddle(4'(k) * {2'b00, q1});
    end
  end

  function automatic logic [DW-1:0] scale(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = (a + RND) >>> TW;
    if (s > MAXV)      return MAXV[DW-1:0];
    else if (s < MINV) return MINV[DW-1:0];
    else               return s[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      x_re[k] <= bf_re[k];
      x_im[k] <= bf_im[k];
      p_rr[k] <= PW'(x_re[k]) * PW'(w_re[k]);
      p_ii[k] <= PW'(x_im[k]) * PW'(w_im[k]);
      p_ri[k] <= PW'(x_re[k]) * PW'(w_im[k]);
      p_ir[k] <= PW'(x_im[k]) * PW'(w_re[k]);
      a_re[k] <= AW'(p_rr[k]) - AW'(p_ii[k]);
      a_im[k] <= AW'(p_ri[k]) + AW'(p_ir[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      q1      <= 2'd0;
      q2      <= 2'd0;
      q3      <= 2'd0;
      exp_q   <= 2'd0;
      seq_err <= 1'b0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      q1 <= q_flag;
      q2 <= q1;
      q3 <= q2;
      // on mismatch we resync to q_flag+1, which is also the in-order successor
      if (in_valid) begin
        if (q_flag != exp_q) seq_err <= 1'b1;
        exp_q <= q_flag + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_0      <= '0;
      out_1      <= '0;
      out_2      <= '0;
      out_3      <= '0;
      out_valid  <= 1'b0;
      out_q      <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= v3;
      frame_done <= v3 && (q3 == 2'd3);
      if (v3) begin
        out_0 <= {scale(a_re[0]), scale(a_im[0])};
        out_1 <= {scale(a_re[1]), scale(a_im[1])};
        out_2 <= {scale(a_re[2]), scale(a_im[2])};
        out_3 <= {scale(a_re[3]), scale(a_im[3])};
        out_q <= q3;
      end
    end
  end

endmodule
